frame_buffer_mp: RTL and testbench

FRAME_BUFFER_MP -- requirements
Module: frame_buffer_mp

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_clear_fsm.sv | 58 +++++
 rtl/frame_buffer_mp.sv | 87 ++++++++
 tb/tb_frame_buffer_mp.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared defaults, controller states and sizing helper for the frame buffer
package fb_pkg;

    localparam int FB_W_DEF    = 120;
    localparam int FB_H_DEF    = 60;
    localparam int PIX_W_DEF   = 3;
    localparam int N_RD_DEF    = 2;
    localparam int CLR_VAL_DEF = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } fb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fb_clear_fsm.sv
// rtl/fb_clear_fsm.sv - clear engine: walks every address once, then gates writes while idle
module fb_clear_fsm
    import fb_pkg::*;
#(
    parameter int DEPTH = FB_W_DEF * FB_H_DEF,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic [AW-1:0] clr_cnt,
    output logic          clr_busy,
    output logic          wr_ready
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    fb_state_t     state;
    fb_state_t     state_nxt;
    logic [AW-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= cnt_nxt;
        end
    end

    // A clear request arriving mid-clear is deliberately dropped, not queued.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = clr_cnt;
        clr_busy  = 1'b0;
        wr_ready  = 1'b0;
        case (state)
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = clr_cnt + 1'b1;
                end
            end
            IDLE: begin
                wr_ready = !clr_req;
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

endmodule

// File: rtl/frame_buffer_mp.sv
// rtl/frame_buffer_mp.sv - single-write, multi-read frame buffer with hardware clear
module frame_buffer_mp
    import fb_pkg::*;
#(
    parameter int               FB_W    = FB_W_DEF,
    parameter int               FB_H    = FB_H_DEF,
    parameter int               PIX_W   = PIX_W_DEF,
    parameter int               N_RD    = N_RD_DEF,
    parameter logic [PIX_W-1:0] CLR_VAL = PIX_W'(CLR_VAL_DEF),
    localparam int              DEPTH   = FB_W * FB_H,
    localparam int              AW      = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic [PIX_W-1:0]      wr_data,
    input  logic                  clr_req,
    output logic                  clr_busy,
    input  logic [N_RD*AW-1:0]    rd_addr,
    output logic [N_RD*PIX_W-1:0] rd_data,
    output logic                  wr_oob
);

    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    clr_cnt;
    logic             wr_fire;
    logic             wr_in_range;

    fb_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_cnt  (clr_cnt),
        .clr_busy (clr_busy),
        .wr_ready (wr_ready)
    );

    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_V;

    // No reset on the array: contents come only from the clear engine.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_busy) begin
                mem[clr_cnt] <= CLR_VAL;
            end else if (wr_fire && wr_in_range) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_oob <= 1'b0;
        end else if (wr_fire && !wr_in_range) begin
            wr_oob <= 1'b1;
        end
    end

    // Non-blocking array read gives read-first behaviour against a same-cycle write.
    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [PIX_W-1:0] data_q;

        assign addr = rd_addr[k*AW +: AW];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (clr_busy || ({1'b0, addr} >= DEPTH_V)) begin
                data_q <= CLR_VAL;
            end else begin
                data_q <= mem[addr];
            end
        end

        assign rd_data[k*PIX_W +: PIX_W] = data_q;
    end

endmodule

// File: tb/tb_frame_buffer_mp.sv
// tb/tb_frame_buffer_mp.sv - randomized self-checking bench for frame_buffer_mp
module tb_frame_buffer_mp;

    localparam int               FB_W    = 120;
    localparam int               FB_H    = 60;
    localparam int               PIX_W   = 3;
    localparam int               N_RD    = 2;
    localparam int               DEPTH   = FB_W * FB_H;
    localparam int               AW      = 13;
    localparam logic [PIX_W-1:0] CLR_VAL = '0;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [AW-1:0]         wr_addr;
    logic [PIX_W-1:0]      wr_data;
    logic                  clr_req;
    logic                  clr_busy;
    logic [N_RD*AW-1:0]    rd_addr;
    logic [N_RD*PIX_W-1:0] rd_data;
    logic                  wr_oob;

    int n_vec = 0;
    int n_err = 0;

    logic [PIX_W-1:0] model [DEPTH];
    logic             oob_m;

    frame_buffer_mp #(
        .FB_W    (FB_W),
        .FB_H    (FB_H),
        .PIX_W   (PIX_W),
        .N_RD    (N_RD),
        .CLR_VAL (CLR_VAL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_oob   (wr_oob)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] exp_rd(input int a);
        if (a >= DEPTH) return CLR_VAL;
        return model[a];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = CLR_VAL;
    endfunction

    // One idle-state cycle: optional write plus two reads, checked against the model.
    task automatic cycle(input logic wv, input int wa, input int wd, input int a0, input int a1);
        logic [PIX_W-1:0] e0, e1;
        wr_valid = wv;
        wr_addr  = AW'(wa);
        wr_data  = PIX_W'(wd);
        rd_addr  = {AW'(a1), AW'(a0)};
        #1;
        chk("wr_ready", {31'd0, wr_ready}, 32'd1);
        e0 = exp_rd(a0);
        e1 = exp_rd(a1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        chk("rd0", {29'd0, rd_data[PIX_W-1:0]}, {29'd0, e0});
        chk("rd1", {29'd0, rd_data[2*PIX_W-1:PIX_W]}, {29'd0, e1});
        if (wv) begin
            if (wa < DEPTH) model[wa] = PIX_W'(wd);
            else oob_m = 1'b1;
        end
        chk("wr_oob", {31'd0, wr_oob}, {31'd0, oob_m});
    endtask

    // Counts cycles with clr_busy high, stopping at limit; reads must be CLR_VAL meanwhile.
    task automatic run_clear(input int req_at, input int limit, output int n, output int rdy_bad);
        n = 0;
        rdy_bad = 0;
        while (clr_busy === 1'b1 && n < limit) begin
            if (wr_ready !== 1'b0) rdy_bad++;
            clr_req = (n == req_at);
            rd_addr = {AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1))};
            @(posedge clk); #1;
            clr_req = 1'b0;
            if (n % 256 == 0) chk("clear_rd", {29'd0, rd_data[PIX_W-1:0]}, {29'd0, CLR_VAL});
            n++;
        end
    endtask

    task automatic readback();
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 0, 0, i, DEPTH - 1 - i);
    endtask

    task automatic random_phase(input int cycles);
        int wa, a0, a1, r;
        for (int i = 0; i < cycles; i++) begin
            r  = $urandom_range(0, 9);
            wa = (r == 0) ? $urandom_range(DEPTH, 8191) :
                 (r < 6)  ? $urandom_range(0, 31) : $urandom_range(0, DEPTH - 1);
            r  = $urandom_range(0, 9);
            a0 = (r == 0) ? $urandom_range(DEPTH, 8191) : $urandom_range(0, 31);
            a1 = (r < 5)  ? $urandom_range(0, 31) : $urandom_range(0, DEPTH - 1);
            cycle($urandom_range(0, 1) == 1, wa, $urandom_range(0, 7), a0, a1);
        end
    endtask

    initial begin
        int n, bad;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        clr_req  = 1'b0;
        rd_addr  = '0;
        oob_m    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, clr_busy}, 32'd1);
        chk("rst_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_rd", {26'd0, rd_data}, 32'd0);
        chk("rst_oob", {31'd0, wr_oob}, 32'd0);

        rst_n = 1'b1;
        run_clear(-1, DEPTH + 16, n, bad);
        chk("clear_len", n, DEPTH);
        chk("clear_ready", bad, 0);
        model_clear();
        readback();

        cycle(1'b1, 1234, 5, 0, 0);
        cycle(1'b0, 0, 0, 1234, 1234);

        cycle(1'b1, 77, 2, 0, 0);
        cycle(1'b1, 77, 6, 77, 77);
        cycle(1'b0, 0, 0, 77, 1234);

        cycle(1'b1, 7200, 3, 7199, 0);
        cycle(1'b0, 0, 0, 8000, 7199);
        cycle(1'b0, 0, 0, 0, 8191);

        random_phase(2000);

        clr_req  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = AW'(500);
        wr_data  = 3'd7;
        #1;
        chk("clr_vs_wr_ready", {31'd0, wr_ready}, 32'd0);
        @(posedge clk); #1;
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        chk("clr_start_busy", {31'd0, clr_busy}, 32'd1);
        run_clear(100, DEPTH + 16, n, bad);
        chk("clear2_len", n, DEPTH);
        chk("clear2_ready", bad, 0);
        model_clear();
        chk("clear2_oob", {31'd0, wr_oob}, {31'd0, oob_m});
        readback();

        random_phase(500);

        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        run_clear(-1, 3000, n, bad);
        chk("pre_rst_len", n, 3000);
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst2_rd", {26'd0, rd_data}, 32'd0);
            chk("rst2_oob", {31'd0, wr_oob}, 32'd0);
            chk("rst2_busy", {31'd0, clr_busy}, 32'd1);
            chk("rst2_ready", {31'd0, wr_ready}, 32'd0);
        end
        rst_n = 1'b1;
        oob_m = 1'b0;
        run_clear(-1, DEPTH + 16, n, bad);
        chk("clear3_len", n, DEPTH);
        chk("clear3_ready", bad, 0);
        model_clear();
        readback();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
